// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem address, prefetch queue
// Redirect flushes the queue and restarts fetch; decode drains via valid/ready.
module fetch_unit #(
  parameter int             N           = 32,
  parameter logic [N-1:0]   RESET_PC    = '0,
  parameter int             QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         out_valid,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc,
  input  logic         out_ready
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  pc_mem_q    [QUEUE_DEPTH];
  logic [N-1:0]  instr_mem_q [QUEUE_DEPTH];

  logic pop;
  logic push;

  // A full queue may still push when its head leaves in the same cycle.
  assign pop  = (count_q != '0) & out_ready;
  assign push = !redirect_valid & ((count_q < CW'(QUEUE_DEPTH)) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[N-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + N'(4);
        wr_ptr_d   = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_instr;
      end
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Directed vector table, then randomized traffic against a queue-based model.
module tb_fetch_unit;

  localparam int          N     = 32;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  fetch_unit #(.N(N), .RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued PCs in arrival order; the word follows from the PC.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_zero;
  bit          m_known;

  task automatic model_edge(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    bit p_pop, p_push;
    if (r) begin
      m_pc = RPC; m_q.delete(); m_zero = 1; m_known = 1;
    end else if (rv) begin
      m_q.delete(); m_pc = rp & 32'hFFFF_FFFC;
    end else begin
      p_pop  = (m_q.size() != 0) && rdy;
      p_push = (m_q.size() < DEPTH) || p_pop;
      if (p_pop) void'(m_q.pop_front());
      if (p_push) begin
        m_q.push_back(m_pc); m_pc = m_pc + 32'd4; m_zero = 0;
      end
    end
  endtask

  task automatic model_check();
    if (!m_known) return;
    chk("model_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    chk("model_addr", imem_addr, m_pc);
    if (m_q.size() != 0) begin
      chk("model_pc", out_pc, m_q[0]);
      chk("model_instr", out_instr, mem_word(m_q[0]));
    end else if (m_zero) begin
      chk("model_pc_zero", out_pc, 32'd0);
      chk("model_instr_zero", out_instr, 32'd0);
    end
  endtask

  // One cycle: drive at negedge, confirm redirect/ready cannot reach imem_addr
  // or out_valid combinationally, clock, then compare against the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    #1;
    if (m_known) begin
      chk("comb_addr", imem_addr, m_pc);
      chk("comb_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    end
    @(posedge clk);
    model_edge(r, rv, rp, rdy);
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ez;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rp, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic ez, input logic [31:0] eaddr);
    vec_t v;
    v.r = r; v.rv = rv; v.rp = rp; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ez = ez; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    m_pc = '0; m_zero = 0; m_known = 0;

    // reset then stream
    add(1, 0, 0, 1, 0, 0,            1, 32'h100);
    add(0, 0, 0, 1, 1, 32'h100,      0, 32'h104);
    add(0, 0, 0, 1, 1, 32'h104,      0, 32'h108);
    add(0, 0, 0, 1, 1, 32'h108,      0, 32'h10C);
    // backpressure, then full queue with simultaneous pop
    add(1, 0, 0, 0, 0, 0,            1, 32'h100);
    add(0, 0, 0, 0, 1, 32'h100,      0, 32'h104);
    add(0, 0, 0, 0, 1, 32'h100,      0, 32'h108);
    add(0, 0, 0, 0, 1, 32'h100,      0, 32'h108);
    add(0, 0, 0, 0, 1, 32'h100,      0, 32'h108);
    add(0, 0, 0, 0, 1, 32'h100,      0, 32'h108);
    add(0, 0, 0, 1, 1, 32'h104,      0, 32'h10C);
    add(0, 0, 0, 1, 1, 32'h108,      0, 32'h110);
    // redirect flush of a full queue, unaligned target
    add(0, 1, 32'h203, 0, 0, 0,      0, 32'h200);
    add(0, 0, 0, 0, 1, 32'h200,      0, 32'h204);
    add(0, 0, 0, 1, 1, 32'h204,      0, 32'h208);
    // redirect with a concurrent pop, then PC wrap
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'hFFFF_FFFC);
    add(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    add(0, 0, 0, 1, 1, 32'h0,        0, 32'h4);
    add(0, 0, 0, 1, 1, 32'h4,        0, 32'h8);
    // reset overrides a simultaneous redirect, stream restarts
    add(1, 1, 32'h300, 1, 0, 0,      1, 32'h100);
    add(0, 0, 0, 1, 1, 32'h100,      0, 32'h104);
    add(0, 0, 0, 1, 1, 32'h104,      0, 32'h108);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].rv, vecs[i].rp, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
        chk($sformatf("vec%0d_instr", i), out_instr, mem_word(vecs[i].epc));
      end else if (vecs[i].ez) begin
        chk($sformatf("vec%0d_pc0", i), out_pc, 32'd0);
        chk($sformatf("vec%0d_instr0", i), out_instr, 32'd0);
      end
    end

    // head stability under a long stall after a redirect
    step(0, 1, 32'h0000_4001, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("stall_head_pc", out_pc, 32'h4000);
      chk("stall_addr", imem_addr, 32'h4008);
    end

    // randomized traffic with varying backpressure bias
    for (int blk = 0; blk < 10; blk++) begin
      int bias;
      bias = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) begin
        logic r, rv, rdy;
        logic [31:0] rp;
        r  = ($urandom_range(0, 63) == 0);
        rv = ($urandom_range(0, 15) == 0);
        rp = $urandom;
        if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        rdy = ($urandom_range(0, 3) >= bias);
        step(r, rv, rp, rdy);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
